// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data width, optional parity and 1/2 stop bits.
// Each word is held in a one-entry valid/ready register together with its parity and framing status.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_dbg
);

  localparam int SW = $clog2(OVS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rxd_m, rxd_s;
  logic [SW-1:0]        s_cnt;
  logic [2:0]           b_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc, par_bad, stop_bad;
  logic                 mid, done;

  // Handshake: a word transfers on any rising clk edge where valid && ready.
  // valid stays high until that transfer; ready may be asserted independently of valid.
  assign mid       = tick && (s_cnt == SW'(OVS - 1));
  assign done      = (state == STOP) && mid && (b_cnt == 3'(STOP_BITS - 1));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      s_cnt      <= '0;
      b_cnt      <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      // A completing frame may replace a word that is being accepted in the same cycle.
      if (done) begin
        if (!valid || ready) begin
          rx_data    <= shreg;
          parity_err <= par_bad;
          frame_err  <= stop_bad | ~rxd_s;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (tick && !rxd_s) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == SW'(OVS / 2 - 1)) begin
              if (!rxd_s) begin
                state    <= DATA;
                s_cnt    <= '0;
                b_cnt    <= '0;
                par_acc  <= 1'b0;
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA, PARITY, STOP: begin
          if (mid) begin
            s_cnt <= '0;
            if (state == DATA) begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              par_acc <= par_acc ^ rxd_s;
              if (b_cnt == 3'(DATA_BITS - 1)) begin
                b_cnt <= '0;
                state <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                b_cnt <= b_cnt + 1'b1;
              end
            end else if (state == PARITY) begin
              par_bad <= par_acc ^ rxd_s ^ 1'(PARITY_ODD);
              state   <= STOP;
            end else begin
              stop_bad <= stop_bad | ~rxd_s;
              if (b_cnt == 3'(STOP_BITS - 1)) begin
                b_cnt <= '0;
                state <= IDLE;
              end else begin
                b_cnt <= b_cnt + 1'b1;
              end
            end
          end else if (tick) begin
            s_cnt <= s_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1/OVS4, 8E2/OVS4, 5O1/OVS16) fed with directed frames,
// expected words queued per receiver and checked by a monitor on each accepted word.
`timescale 1ns/1ps
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tick;
  logic [2:0] rxd_v;
  logic [2:0] ready_v;

  logic [7:0] rx0, rx1;
  logic [4:0] rx2;
  logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;
  logic [2:0] s0, s1, s2;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_cnt[3];

  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] exp_q2[$];

  uart_rx_param #(.DATA_BITS(8), .OVS(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .n_rst(n_rst), .tick(tick), .rxd(rxd_v[0]), .rx_data(rx0), .valid(v0),
    .ready(ready_v[0]), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .state_dbg(s0));

  uart_rx_param #(.DATA_BITS(8), .OVS(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .n_rst(n_rst), .tick(tick), .rxd(rxd_v[1]), .rx_data(rx1), .valid(v1),
    .ready(ready_v[1]), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .state_dbg(s1));

  uart_rx_param #(.DATA_BITS(5), .OVS(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .n_rst(n_rst), .tick(tick), .rxd(rxd_v[2]), .rx_data(rx2), .valid(v2),
    .ready(ready_v[2]), .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .state_dbg(s2));

  // clock / tick / watchdog
  always #5 clk = ~clk;

  initial begin
    int c;
    c    = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c    = (c + 1) % 4;
      tick = (c == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end within the time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!tick);
    end
  endtask

  task automatic drive_bit(input int inst, input logic b, input int ovs);
    rxd_v[inst] = b;
    wait_ticks(ovs);
    #1;
  endtask

  task automatic send(input int inst, input logic [7:0] d, input logic par, input logic stop2);
    int ovs;
    int nb;
    ovs = (inst == 2) ? 16 : 4;
    nb  = (inst == 2) ? 5 : 8;
    wait_ticks(1);
    #1;
    drive_bit(inst, 1'b0, ovs);
    for (int i = 0; i < nb; i++) drive_bit(inst, d[i], ovs);
    if (inst != 0) drive_bit(inst, par, ovs);
    drive_bit(inst, 1'b1, ovs);
    if (inst == 1) drive_bit(inst, stop2, ovs);
    rxd_v[inst] = 1'b1;
    wait_ticks(ovs);
    #1;
  endtask

  task automatic push(input int inst, input logic pe, input logic fe, input logic [7:0] d);
    case (inst)
      0:       exp_q0.push_back({pe, fe, d});
      1:       exp_q1.push_back({pe, fe, d});
      default: exp_q2.push_back({pe, fe, d});
    endcase
  endtask

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int inst, input logic [9:0] act);
    logic [9:0] e;
    logic       found;
    found = 1'b0;
    e     = '0;
    case (inst)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); found = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); found = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); found = 1'b1; end
    endcase
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL word_unexpected rx%0d: got {pe,fe,data}=0x%0h, expected no word", inst, act);
    end else if (act !== e) begin
      n_fail++;
      $display("FAIL word rx%0d: got {pe,fe,data}=0x%0h expected 0x%0h", inst, act, e);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (v0 && ready_v[0]) pop_cmp(0, {pe0, fe0, rx0});
        if (v1 && ready_v[1]) pop_cmp(1, {pe1, fe1, rx1});
        if (v2 && ready_v[2]) pop_cmp(2, {pe2, fe2, 3'b000, rx2});
        if (ov0) ov_cnt[0]++;
        if (ov1) ov_cnt[1]++;
        if (ov2) ov_cnt[2]++;
      end
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {31'd0, v0, v1, v2, rx0, rx1, rx2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2};
  endfunction

  // directed sequence
  initial begin
    for (int i = 0; i < 3; i++) ov_cnt[i] = 0;
    rxd_v   = 3'b111;
    ready_v = 3'b111;
    n_rst   = 1'b0;
    fork monitor(); join_none

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    check("reset_states", {s0, s1, s2}, 9'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (4) @(posedge clk);

    // 8N1 words delivered with ready held high
    push(0, 1'b0, 1'b0, 8'hA5);
    send(0, 8'hA5, 1'b0, 1'b1);
    push(0, 1'b0, 1'b0, 8'h3C);
    send(0, 8'h3C, 1'b0, 1'b1);

    // even parity, two stop bits
    push(1, 1'b1, 1'b0, 8'h03);
    send(1, 8'h03, 1'b1, 1'b1);
    push(1, 1'b0, 1'b0, 8'h03);
    send(1, 8'h03, 1'b0, 1'b1);
    push(1, 1'b0, 1'b1, 8'h5A);
    send(1, 8'h5A, 1'b0, 1'b0);
    push(1, 1'b1, 1'b0, 8'h80);
    send(1, 8'h80, 1'b0, 1'b1);

    // one-tick glitch on an idle line is rejected
    wait_ticks(1);
    #1;
    rxd_v[0] = 1'b0;
    wait_ticks(1);
    #1;
    rxd_v[0] = 1'b1;
    wait_ticks(8);
    @(negedge clk);
    check("glitch_valid", v0, 1'b0);
    check("glitch_state_idle", s0, 3'd0);
    check("glitch_flags", {pe0, fe0, ov0}, 3'b000);
    push(0, 1'b0, 1'b0, 8'h11);
    send(0, 8'h11, 1'b0, 1'b1);

    // output register full: second frame is dropped with an overrun pulse
    ready_v[0] = 1'b0;
    push(0, 1'b0, 1'b0, 8'h12);
    send(0, 8'h12, 1'b0, 1'b1);
    send(0, 8'h34, 1'b0, 1'b1);
    @(negedge clk);
    check("overrun_count", ov_cnt[0], 1);
    check("overrun_valid_held", v0, 1'b1);
    check("overrun_data_held", rx0, 8'h12);
    @(posedge clk);
    #1;
    ready_v[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("accept_clears_valid", v0, 1'b0);
    check("accept_data_holds", rx0, 8'h12);

    // acceptance in the completion cycle lets the new frame load without overrun
    ready_v[0] = 1'b0;
    push(0, 1'b0, 1'b0, 8'h56);
    send(0, 8'h56, 1'b0, 1'b1);
    push(0, 1'b0, 1'b0, 8'h34);
    fork
      send(0, 8'h34, 1'b0, 1'b1);
      begin
        wait_ticks(39);
        #1;
        while (!tick) begin
          @(posedge clk);
          #1;
        end
        ready_v[0] = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("same_cycle_no_overrun", ov_cnt[0], 1);
    check("same_cycle_valid_done", v0, 1'b0);
    check("same_cycle_data", rx0, 8'h34);

    // reset mid-frame on rx2 while rx1 holds an unaccepted word
    ready_v[1] = 1'b0;
    push(1, 1'b0, 1'b0, 8'h77);
    send(1, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    check("rx1_holding_before_reset", {v1, rx1}, {1'b1, 8'h77});
    wait_ticks(1);
    #1;
    rxd_v[2] = 1'b0;
    wait_ticks(30);
    #1;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs", all_outs(), 64'd0);
    check("mid_reset_states", {s0, s1, s2}, 9'd0);
    exp_q1.delete();
    rxd_v[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst      = 1'b1;
    ready_v[1] = 1'b1;

    // 5-bit odd parity words after reset
    push(2, 1'b0, 1'b0, 8'h1F);
    send(2, 8'h1F, 1'b0, 1'b1);
    push(2, 1'b1, 1'b0, 8'h03);
    send(2, 8'h03, 1'b0, 1'b1);
    push(2, 1'b0, 1'b0, 8'h03);
    send(2, 8'h03, 1'b1, 1'b1);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("queue0_drained", exp_q0.size(), 0);
    check("queue1_drained", exp_q1.size(), 0);
    check("queue2_drained", exp_q2.size(), 0);
    check("overrun_total_rx1", ov_cnt[1], 0);
    check("overrun_total_rx2", ov_cnt[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
